// File: rtl/pipeline_trace_buffer_if.sv
// pipeline_trace_buffer_if: capture, control and readback signals of the pipeline trace buffer.
interface pipeline_trace_buffer_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NUM_CH + 1);
    logic                    arm;
    logic                    sample_valid;
    logic [NUM_CH*WIDTH-1:0] sample_data;
    logic                    trigger;
    logic                    rd_en;
    logic [AW-1:0]           rd_addr;
    logic [CW-1:0]           rd_ch;
    logic [WIDTH-1:0]        rd_data;
    logic                    rd_valid;
    logic [1:0]              state;
    logic                    done;
    logic [AW:0]             count;
    logic [AW-1:0]           trig_pos;
    modport master (
        output arm, sample_valid, sample_data, trigger, rd_en, rd_addr, rd_ch,
        input  rd_data, rd_valid, state, done, count, trig_pos
    );
    modport slave (
        input  arm, sample_valid, sample_data, trigger, rd_en, rd_addr, rd_ch,
        output rd_data, rd_valid, state, done, count, trig_pos
    );
endinterface

// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer: circular capture of NUM_CH probe channels with trigger and post-trigger window.
// Optional TRACE_TIMESTAMP_EN stores a cycle timestamp per sample, read back on rd_ch = NUM_CH.
module pipeline_trace_buffer #(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    parameter int TS_WIDTH  = 16
) (
    input logic clk,
    input logic reset,
    pipeline_trace_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3;
    localparam logic [AW:0] PT = POST_TRIG[AW:0];
    localparam logic [AW-1:0] PT_LAST = AW'(POST_TRIG - 1);
    logic [1:0]              state;
    logic [AW-1:0]           wr_ptr, post_cnt, trig_pos, phys;
    logic [AW:0]             count, cnt_nx;
    logic [WIDTH-1:0]        rd_data, rd_word, chan_word, ts_word;
    logic                    rd_valid, done, we, go_done, in_range;
    logic [NUM_CH*WIDTH-1:0] mem [DEPTH];
    logic [NUM_CH*WIDTH-1:0] word;
    always_comb begin
        we        = !bus.arm && bus.sample_valid && (state == ARMED || state == POST);
        cnt_nx    = count[AW] ? count : count + 1'b1;
        go_done   = state == ARMED ? bus.trigger && POST_TRIG == 0 : post_cnt == PT_LAST;
        phys      = (count[AW] ? wr_ptr : '0) + bus.rd_addr;
        word      = mem[phys];
        in_range  = {1'b0, bus.rd_addr} < count;
        chan_word = WIDTH'(word >> (32'(bus.rd_ch) * WIDTH));
        rd_word   = !in_range ? '0 :
                    32'(bus.rd_ch) < NUM_CH ? chan_word :
                    32'(bus.rd_ch) == NUM_CH ? ts_word : '0;
    end
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] ts_mem [DEPTH];
    always_ff @(posedge clk) begin
        ts <= (reset || bus.arm) ? '0 : ts + 1'b1;
        if (we && !reset) ts_mem[wr_ptr] <= ts;
    end
    assign ts_word = WIDTH'(ts_mem[phys]);
`else
    // No timestamp storage: the timestamp channel reads as zero.
    logic [TS_WIDTH-1:0] ts_zero;
    assign ts_zero = '0;
    assign ts_word = WIDTH'(ts_zero);
`endif
    always_ff @(posedge clk) begin
        if (we && !reset) mem[wr_ptr] <= bus.sample_data;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            count    <= '0;
            post_cnt <= '0;
            trig_pos <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_valid <= bus.rd_en && state == DONE;
            rd_data  <= (bus.rd_en && state == DONE) ? rd_word : '0;
            if (bus.arm) begin
                state    <= ARMED;
                wr_ptr   <= '0;
                count    <= '0;
                post_cnt <= '0;
                done     <= 1'b0;
            end else if (we) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= cnt_nx;
                if (state == POST) post_cnt <= post_cnt + 1'b1;
                // trig_pos is taken from the count after this final write
                if (go_done) begin
                    state    <= DONE;
                    done     <= 1'b1;
                    trig_pos <= AW'(cnt_nx - 1'b1 - PT);
                end else if (state == ARMED && bus.trigger) begin
                    state <= POST;
                end
            end
        end
    end
    assign bus.state    = state;
    assign bus.done     = done;
    assign bus.count    = count;
    assign bus.trig_pos = trig_pos;
    assign bus.rd_data  = rd_data;
    assign bus.rd_valid = rd_valid;
endmodule

// File: doc/pipeline_trace_buffer.md
Name: pipeline_trace_buffer

Overview:
- Parametrised, synthesizable capture buffer for probing CPU pipeline state (PC, register-file words, stack words).
- Records NUM_CH channels of WIDTH bits into a circular RAM of DEPTH entries, with a trigger and a programmable post-trigger window.
- Captured samples are read back through a random-access port, indexed oldest-first.
- Sits beside the CPU core; sample_data is wired to pipeline/register nets.

Parameters:
- NUM_CH, 4, number of probe channels per sample.
- WIDTH, 32, bits per channel.
- DEPTH, 16, samples held; must be a power of two, at least 2.
- POST_TRIG, 4, samples stored after the trigger sample; must be at most DEPTH-1.
- TS_WIDTH, 16, timestamp width; used only with TRACE_TIMESTAMP_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- arm  in  1  pulse; clears the buffer and starts capture.
- sample_valid  in  1  qualifies sample_data and trigger this cycle.
- sample_data  in  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- trigger  in  1  trigger condition; honoured only with sample_valid.
- rd_en  in  1  read request.
- rd_addr  in  log2(DEPTH)  logical index; 0 = oldest stored sample.
- rd_ch  in  log2(NUM_CH+1)  channel select.
- rd_data  out  WIDTH  read result.
- rd_valid  out  1  rd_data valid; one-cycle pulse.
- state  out  2  0 = IDLE, 1 = ARMED, 2 = POST, 3 = DONE.
- done  out  1  high in DONE.
- count  out  log2(DEPTH)+1  stored samples; saturates at DEPTH.
- trig_pos  out  log2(DEPTH)  logical index of the trigger sample; valid when done = 1.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state = IDLE; wr_ptr, count, post_cnt, trig_pos, rd_data, rd_valid, done all 0.
- Reset priority: reset overrides every other input, mid-operation included. RAM contents are don't-care after reset.
- IDLE: sample_valid and trigger are ignored. arm moves to ARMED.
- arm, any state: on the next edge state = ARMED; wr_ptr, count and post_cnt are cleared. A sample_valid in the same cycle is dropped.
- ARMED, sample_valid = 1:
  - Write the sample to buf[wr_ptr]; wr_ptr increments, wrapping mod DEPTH; count saturates at DEPTH.
  - If trigger = 1, this sample is the trigger sample. Go to POST, or straight to DONE when POST_TRIG = 0.
  - A trigger before the buffer fills is legal; fewer pre-trigger samples are kept.
- POST, sample_valid = 1: store as in ARMED and increment post_cnt. When post_cnt reaches POST_TRIG, go to DONE; done rises on the same edge as the last write. trigger is ignored.
- DONE: no writes; all contents frozen until arm or reset.
- Addressing:
  - oldest = 0 when count < DEPTH, otherwise wr_ptr.
  - Physical index = (oldest + rd_addr) mod DEPTH.
  - trig_pos = count - 1 - POST_TRIG.
- Read, one-cycle latency: rd_en at edge N gives rd_valid = 1 and rd_data at edge N+1.
  - Only in DONE.
  - rd_addr >= count, or rd_ch >= NUM_CH: rd_data = 0, still with rd_valid = 1.
  - rd_en outside DONE: rd_valid = 0, rd_data = 0.
- Widths: all pointer arithmetic is mod DEPTH; count is one bit wider than the pointer.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - A TS_WIDTH free-running cycle counter is cleared by reset and by arm, and wraps at 2^TS_WIDTH.
  - Its value is stored with every sample.
  - rd_ch = NUM_CH returns the stored timestamp, zero-extended or truncated to WIDTH.
- Undefined: no counter and no storage; rd_ch = NUM_CH returns 0.

Test Plan:
All scenarios use NUM_CH = 2, WIDTH = 32, DEPTH = 8, POST_TRIG = 2. Sample k carries ch0 = k, ch1 = 0x100 + k.
1. Reset, arm, samples 1..3, sample 4 with trigger, samples 5..6 -> done = 1, count = 6, trig_pos = 3. Read addr 0 ch0 gives 1; addr 3 ch1 gives 0x104; addr 6 gives 0 with rd_valid = 1.
2. Wrap: samples 1..12, sample 13 with trigger, samples 14..15 -> count = 8, trig_pos = 5. Read addr 0 ch0 gives 8; addr 7 ch0 gives 15.
3. Gaps: sample_valid held low 3 cycles between post samples -> state stays POST until the second post sample. trigger pulses while sample_valid = 0 are ignored.
4. Reset asserted in POST -> next edge state = 0, count = 0, done = 0. rd_en afterwards gives rd_valid = 0.
5. In DONE, arm together with sample_valid (data 99) -> state = ARMED, count = 0; the sample is not stored. Re-trigger flow stores fresh data only.
6. TRACE_TIMESTAMP_EN defined: arm at cycle 0, samples on cycles 2, 5, 9 (trigger at 5) -> rd_ch = 2 returns 2, 5, 9 in logical order.
